// File: rtl/lfpm_pkg.sv
// Shared types, status bit positions and width helpers for the byte-serial
// Mitchell log-domain multiplier.
package lfpm_pkg;

  typedef enum logic [1:0] {
    S_LOAD,
    S_CALC,
    S_OUT,
    S_STAT
  } lfpm_state_e;

  localparam int ST_INVALID = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_UNF     = 2;
  localparam int ST_ZIN     = 3;

  function automatic int nbytes(input int w);
    return (w + 7) / 8;
  endfunction

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/lfpm_mitchell_core.sv
// Combinational Mitchell multiplier: adds exponents and mantissas directly,
// which approximates the product in the log domain, plus IEEE-style specials.
module lfpm_mitchell_core #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] p,
  output logic [3:0]           status
);
  import lfpm_pkg::*;

  localparam int BIAS = bias(EXP_W);
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);

  logic               sa, sb, s;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [MAN_W:0]     msum;
  logic signed [EXP_W+1:0] e_res;

  always_comb begin
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    s      = sa ^ sb;
    nan_a  = (&ea) && (|ma);
    nan_b  = (&eb) && (|mb);
    inf_a  = (&ea) && !(|ma);
    inf_b  = (&eb) && !(|mb);
    zero_a = !(|ea);
    zero_b = !(|eb);
    msum   = {1'b0, ma} + {1'b0, mb};
    // Mantissa carry bumps the exponent; evaluated wide and signed so the
    // overflow and underflow bounds are both visible.
    e_res  = signed'({2'b00, ea}) + signed'({2'b00, eb}) - BIAS_S
           + signed'({{(EXP_W+1){1'b0}}, msum[MAN_W]});

    status = 4'h0;
    p      = {s, e_res[EXP_W-1:0], msum[MAN_W-1:0]};
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      p = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      status[ST_INVALID] = 1'b1;
    end else if (inf_a || inf_b) begin
      p = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      p = {s, {(EXP_W+MAN_W){1'b0}}};
      status[ST_ZIN] = 1'b1;
    end else if (e_res >= E_MAX) begin
      p = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      status[ST_OVF] = 1'b1;
    end else if (e_res <= 0) begin
      p = {s, {(EXP_W+MAN_W){1'b0}}};
      status[ST_UNF] = 1'b1;
    end
  end

endmodule

// File: rtl/tt_um_lfpm_serial.sv
// Byte-serial wrapper: loads A/B low byte first, computes one product, then
// streams the result bytes followed by a status byte on uo_out.
module tt_um_lfpm_serial #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import lfpm_pkg::*;

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int NBYTES = nbytes(W);
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam logic [W-1:0] BYTE_MASK = W'(8'hFF);

  lfpm_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, b_q, res_q, prod, ld_mask;
  logic [3:0]       st_q, prod_st;
  logic [7:0]       uo_d;
  logic             load_en, calc_en;
  logic [IDX_W+2:0] sh;

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  lfpm_mitchell_core #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_core (
    .a     (a_q),
    .b     (b_q),
    .p     (prod),
    .status(prod_st)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_en = 1'b0;
    calc_en = 1'b0;
    uo_d    = 8'h00;
    sh      = {idx_q, 3'b000};
    ld_mask = BYTE_MASK << sh;
    if (!ena) begin
      state_d = S_LOAD;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          load_en = 1'b1;
          if (idx_q == IDX_W'(NBYTES - 1)) begin
            state_d = S_CALC;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_CALC: begin
          calc_en = 1'b1;
          uo_d    = 8'(prod);
          state_d = S_OUT;
          idx_d   = IDX_W'(1);
        end
        S_OUT: begin
          // One slot past the last result byte carries the status byte.
          if (idx_q == IDX_W'(NBYTES)) begin
            uo_d    = {4'h0, st_q};
            state_d = S_STAT;
            idx_d   = '0;
          end else begin
            uo_d  = 8'(res_q >> sh);
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_STAT: begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
        default: begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Operand bytes beyond W fall off the top of the shift, so padding bits of
  // the last input byte are dropped and padding bits of the last output byte read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      st_q   <= '0;
      uo_out <= '0;
    end else begin
      uo_out <= uo_d;
      if (load_en) begin
        a_q <= (a_q & ~ld_mask) | ((W'(ui_in) << sh) & ld_mask);
        b_q <= (b_q & ~ld_mask) | ((W'(uio_in) << sh) & ld_mask);
      end
      if (calc_en) begin
        res_q <= prod;
        st_q  <= prod_st;
      end
    end
  end

endmodule

// File: tb/tb_tt_um_lfpm_serial.sv
// Directed bench for tt_um_lfpm_serial in FP16, bfloat16 and FP32 shapes,
// checked cycle by cycle against a log-domain reference model.
module tb_tt_um_lfpm_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena16, enabf, ena32;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo16, uobf, uo32;
  logic [7:0] uioo16, uioobf, uioo32, oe16, oebf, oe32;

  always #5 clk = ~clk;

  tt_um_lfpm_serial u_fp16 (
    .clk(clk), .rst_n(rst_n), .ena(ena16), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo16), .uio_out(uioo16), .uio_oe(oe16));

  tt_um_lfpm_serial #(.EXP_W(8), .MAN_W(7)) u_bf16 (
    .clk(clk), .rst_n(rst_n), .ena(enabf), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uobf), .uio_out(uioobf), .uio_oe(oebf));

  tt_um_lfpm_serial #(.EXP_W(8), .MAN_W(23)) u_fp32 (
    .clk(clk), .rst_n(rst_n), .ena(ena32), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo32), .uio_out(uioo32), .uio_oe(oe32));

  int         n_chk  = 0;
  int         n_fail = 0;
  int         sel    = 0;
  logic       chk_en = 1'b0;
  logic [7:0] exp_uo = 8'h00;
  string      tag    = "idle";
  logic [7:0] uo_sel;

  always_comb uo_sel = (sel == 0) ? uo16 : (sel == 1) ? uobf : uo32;

  // Per-cycle compare, sampled just after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      n_chk++;
      if (uo_sel !== exp_uo) begin
        n_fail++;
        $display("FAIL %s: uo_out=%02h expected %02h at %0t", tag, uo_sel, exp_uo, $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: Mitchell product is the sum of the operands' log-domain codes
  // (biased exponent . mantissa as one fixed-point number) minus the bias.
  function automatic longint model(longint a, longint b, int ew, int mw);
    longint one = 1;
    longint emask = (one << ew) - 1;
    longint mmask = (one << mw) - 1;
    longint biasv = (one << (ew - 1)) - 1;
    longint sa = (a >> (ew + mw)) & 1, sb = (b >> (ew + mw)) & 1;
    longint ea = (a >> mw) & emask, eb = (b >> mw) & emask;
    longint ma = a & mmask, mb = b & mmask;
    longint sgn = (sa ^ sb) << (ew + mw);
    longint inf = sgn | (emask << mw);
    longint lp;
    bit nan_a = (ea == emask) && (ma != 0), nan_b = (eb == emask) && (mb != 0);
    bit inf_a = (ea == emask) && (ma == 0), inf_b = (eb == emask) && (mb == 0);
    bit z_a = (ea == 0), z_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a))
      return (longint'(1) << 32) | (emask << mw) | (one << (mw - 1));
    if (inf_a || inf_b) return inf;
    if (z_a || z_b) return (longint'(8) << 32) | sgn;
    lp = (ea << mw) + ma + (eb << mw) + mb - (biasv << mw);
    if (lp >= (emask << mw)) return (longint'(2) << 32) | inf;
    if (lp < (one << mw)) return (longint'(4) << 32) | sgn;
    return sgn | lp;
  endfunction

  task automatic check(string name, longint got, longint want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic cyc(int s, logic en, logic [7:0] ab, logic [7:0] bb,
                     logic [7:0] ex, logic ck);
    @(negedge clk);
    sel    = s;
    ena16  = (s == 0) && en;
    enabf  = (s == 1) && en;
    ena32  = (s == 2) && en;
    ui_in  = ab;
    uio_in = bb;
    exp_uo = ex;
    chk_en = ck;
  endtask

  task automatic run_frame(int s, string name, longint a, longint b,
                           longint lit_res, longint lit_st);
    int ew = (s == 0) ? 5 : 8;
    int mw = (s == 0) ? 10 : (s == 1) ? 7 : 23;
    int nb = (s == 2) ? 4 : 2;
    longint m = model(a, b, ew, mw);
    logic [7:0] val [0:15];
    logic [7:0] ab, bb;
    check({name, " model result"}, m & 64'hFFFF_FFFF, lit_res);
    check({name, " model status"}, m >> 32, lit_st);
    for (int c = 0; c < 16; c++) val[c] = 8'h00;
    for (int j = 0; j < nb; j++) val[nb + 1 + j] = 8'(m >> (8 * j));
    val[2 * nb + 1] = 8'(m >> 32);
    tag = name;
    for (int t = 0; t <= 2 * nb + 1; t++) begin
      ab = (t < nb) ? 8'(a >> (8 * t)) : 8'hA5;
      bb = (t < nb) ? 8'(b >> (8 * t)) : 8'h5A;
      cyc(s, 1'b1, ab, bb, val[t + 1], 1'b1);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena16  = 1'b0;
    enabf  = 1'b0;
    ena32  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) @(negedge clk);
    check("reset uo fp16", uo16, 0);
    check("reset uo bf16", uobf, 0);
    check("reset uo fp32", uo32, 0);
    check("uio_out/oe tied", {uioo16, oe16, uioobf, oebf, uioo32, oe32}, 0);
    rst_n = 1'b1;

    run_frame(0, "fp16 1.5x3",    64'h3E00, 64'h4200, 64'h4400, 0);
    run_frame(0, "fp16 1x-5",     64'h3C00, 64'hC500, 64'hC500, 0);
    run_frame(0, "fp16 inf*0",    64'h7C00, 64'h0000, 64'h7E00, 1);
    run_frame(0, "fp16 inf*-1",   64'h7C00, 64'hBC00, 64'hFC00, 0);
    run_frame(0, "fp16 subn in",  64'h0001, 64'h3C00, 64'h0000, 8);
    run_frame(0, "fp16 ovf",      64'h7800, 64'h7800, 64'h7C00, 2);
    run_frame(0, "fp16 unf",      64'h0400, 64'h0400, 64'h0000, 4);
    run_frame(0, "fp16 nan sign", 64'h7E01, 64'hBC00, 64'h7E00, 1);
    run_frame(0, "fp16 mant",     64'h3555, 64'h3AAA, 64'h33FF, 0);
    run_frame(0, "fp16 -2x-2",    64'hC000, 64'hC000, 64'h4400, 0);

    // ena low in LOAD(1): output stays 0 and the next frame restarts at byte 0
    tag = "ena drop load";
    cyc(0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(0, 1'b0, 8'h3E, 8'h42, 8'h00, 1'b1);
    run_frame(0, "fp16 after ena drop", 64'h3E00, 64'h4200, 64'h4400, 0);

    // ena low while streaming: output clears on the next edge
    tag = "ena drop out";
    cyc(0, 1'b1, 8'h55, 8'hAA, 8'h00, 1'b1);
    cyc(0, 1'b1, 8'h35, 8'h3A, 8'h00, 1'b1);
    cyc(0, 1'b1, 8'hA5, 8'h5A, 8'hFF, 1'b1);
    cyc(0, 1'b0, 8'hA5, 8'h5A, 8'h00, 1'b1);
    run_frame(0, "fp16 after out drop", 64'h3C00, 64'hC500, 64'hC500, 0);

    // asynchronous reset mid-stream
    tag = "reset in out";
    cyc(0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc(0, 1'b1, 8'h3E, 8'h42, 8'h00, 1'b1);
    cyc(0, 1'b1, 8'hA5, 8'h5A, 8'h00, 1'b1);
    cyc(0, 1'b1, 8'hA5, 8'h5A, 8'h44, 1'b1);
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    ena16  = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async reset uo", uo16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, "fp16 after reset", 64'h3E00, 64'h4200, 64'h4400, 0);

    run_frame(1, "bf16 1.5x3",  64'h3FC0, 64'h4040, 64'h4080, 0);
    run_frame(1, "bf16 ovf",    64'h7F00, 64'h7F00, 64'h7F80, 2);
    run_frame(2, "fp32 1.5x3",  64'h3FC0_0000, 64'h4040_0000, 64'h4080_0000, 0);
    run_frame(2, "fp32 inf*0",  64'h7F80_0000, 64'h0000_0000, 64'h7FC0_0000, 1);

    @(negedge clk);
    chk_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_lfpm_serial.md
Name: tt_um_lfpm_serial

Overview:
Parametrised successor to the team's byte-serial logarithmic (Mitchell) approximate FP multiplier.
- Operand width is configurable through exponent and mantissa widths (FP16, bfloat16, FP32-style).
- Operands load low byte first: A on ui_in, B on uio_in.
- Result is streamed back on uo_out, followed by a status byte with IEEE-style exception flags.
- Framing is controlled by ena; there is no fixed two-cycle load.

Parameters:
EXP_W, 5, exponent width (3..8)
MAN_W, 10, stored mantissa width (2..23); W = 1+EXP_W+MAN_W must be at most 32
BIAS, 2**(EXP_W-1)-1, exponent bias (derived; not overridden)
NBYTES, ceil(W/8), bytes per operand and per result (derived)

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  frame enable; low forces frame restart
ui_in  input  8  operand A byte stream, LSB byte first
uio_in  input  8  operand B byte stream, LSB byte first
uo_out  output  8  result byte stream, then status byte
uio_out  output  8  tied 8'h00
uio_oe  output  8  tied 8'h00 (all uio are inputs)

Behaviour:
- Reset: one clock, reset asynchronous and active-low. rst_n=0 immediately clears state to LOAD(k=0), uo_out=0, operand registers=0, result and status registers=0.
- FSM states and per-state actions:
  - LOAD(k), k=0..NBYTES-1: on the clock edge, capture ui_in/uio_in into byte k of A/B. k=NBYTES-1 goes to CALC.
  - CALC: compute product into the result register; uo_out <= result byte 0; go to OUT(1).
  - OUT(k): uo_out <= result byte k. After the last byte, uo_out <= status; go to STAT.
  - STAT: go to LOAD(0); uo_out <= 0.
- Frame timing: NBYTES load cycles, 1 CALC cycle, NBYTES result cycles, 1 status cycle. Total is 2*NBYTES+2 cycles (6 for the default).
- uo_out is registered. It is 0 throughout LOAD and CALC cycles. It is valid during the NBYTES+1 cycles that follow CALC.
- ena=0 at any edge: synchronous return to LOAD(0) and uo_out <= 0. Operand registers hold their values. A frame restarts from byte 0 once ena=1.
- Unused bits when W is not a multiple of 8:
  - input: top bits of the last byte are ignored;
  - output: top bits of the last byte are 0.
- Sign: sA XOR sB. NaN results always carry sign 0.
- Normal path (Mitchell):
  - msum = mA+mB, MAN_W+1 bits; c = msum[MAN_W].
  - e = eA+eB-BIAS+c, evaluated signed on EXP_W+2 bits.
  - Result mantissa = msum[MAN_W-1:0], truncated, no rounding.
- Special-case priority, highest first:
  1. Either operand NaN, or inf×zero: canonical qNaN (exp all ones, mantissa MSB=1, FP16 0x7E00); status bit0 (invalid).
  2. Either operand inf: signed inf; status 0.
  3. Either exp==0 (zero or subnormal, flushed): signed zero; status bit3.
  4. e >= 2^EXP_W-1: signed inf; status bit1 (overflow).
  5. e <= 0: signed zero; status bit2 (underflow).
- Status byte: bits 3:0 as above; bits 7:4 are 0.

Decomposition:
- Package lfpm_pkg holds:
  - FSM state enum;
  - status bit index constants (ST_INVALID=0, ST_OVF=1, ST_UNF=2, ST_ZIN=3);
  - functions nbytes(w) and bias(exp_w).
- Sub-module lfpm_mitchell_core is purely combinational, parametrised by EXP_W and MAN_W.
  - Inputs: operand words. Outputs: result word and 4-bit status.
  - The top level holds the FSM, operand and result registers, and byte muxing.

Test Plan:
- Default FP16 Mitchell product: A=0x3E00 (1.5), B=0x4200 (3.0), bytes {00,00} then {3E,42}, ena=1 → uo_out 0x00, 0x44, 0x00 in cycles 3,4,5 after frame start (4.0, approximation of 4.5); uo_out=0 during cycles 0-2.
- Exact case and sign: 0x3C00 × 0xC500 → 0xC500, status 0x00. Back-to-back frames with no gap give correct results in each.
- Specials:
  - 0x7C00 × 0x0000 → 0x7E00, status 0x01.
  - 0x7C00 × 0xBC00 → 0xFC00, status 0x00.
  - 0x0001 × 0x3C00 → 0x0000, status 0x08.
- Range limits:
  - 0x7800 × 0x7800 → 0x7C00, status 0x02.
  - 0x0400 × 0x0400 → 0x0000, status 0x04.
- Control:
  - ena dropped during LOAD(1) → next-cycle uo_out=0 and byte index restarts; a following full 3E00×4200 frame yields 0x4400.
  - rst_n pulsed low during OUT → uo_out=0 immediately, without waiting for a clock edge.
- Parametrisation:
  - EXP_W=8, MAN_W=7: 0x3FC0 × 0x4040 → 0x4080, 6-cycle frame.
  - EXP_W=8, MAN_W=23: 0x3FC00000 × 0x40400000 → 0x40800000, 10-cycle frame, status 0x00.
